reset_seq: RTL and testbench

Reset sequencer between the PLL lock detector and the SoC core. It replaces the ad-hoc lock counter in the top level with a staged release: peripherals first, then the CPU. It re-enters reset on PLL lock loss, a debounced push-button, or a watchdog timeout, and records the cause in a sticky register the firmware can read.

---
 rtl/reset_seq_pkg.sv | 9 +
 rtl/reset_seq_debounce.sv | 30 +++
 rtl/reset_seq.sv | 101 ++++++++++
 tb/tb_reset_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared types and constants for the reset sequencer.
package reset_seq_pkg;
   typedef enum logic [1:0] {HOLD, PERIPH, RUN} state_t;
   localparam int CAUSE_W   = 4;
   localparam int CAUSE_POR  = 0;
   localparam int CAUSE_LOCK = 1;
   localparam int CAUSE_BTN  = 2;
   localparam int CAUSE_WDT  = 3;
endpackage

// File: rtl/reset_seq_debounce.sv
// debounce: one press pulse after DEBOUNCE_CYCLES consecutive high cycles, re-armed by a low cycle.
module debounce
   import reset_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);
   localparam int W = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [W-1:0] TERM = W'(DEBOUNCE_CYCLES - 1);
   logic [W-1:0] cnt_q, cnt_d;
   logic         done_q, done_d;
   always_comb begin
      press  = btn && cnt_q == TERM && !done_q;
      cnt_d  = !btn ? '0 : (cnt_q == TERM ? cnt_q : cnt_q + 1'b1);
      done_d = btn && (done_q || press);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end
endmodule

// File: rtl/reset_seq.sv
// reset_seq: staged peripheral/CPU reset release with lock-loss, button and watchdog re-entry.
module reset_seq
   import reset_seq_pkg::*;
#(
   parameter int LOCK_CYCLES     = 16,
   parameter int STAGE_CYCLES    = 8,
   parameter int DEBOUNCE_CYCLES = 1024,
   parameter int WDT_CYCLES      = 2**24
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pll_locked,
   input  logic               btn_reset,
   input  logic               wdt_en,
   input  logic               wdt_kick,
   input  logic               cause_clr,
   output logic               periph_reset,
   output logic               cpu_reset,
   output logic [CAUSE_W-1:0] cause
);
   localparam int LW = LOCK_CYCLES > 1 ? $clog2(LOCK_CYCLES) : 1;
   localparam int SW = STAGE_CYCLES > 1 ? $clog2(STAGE_CYCLES) : 1;
   localparam int WW = WDT_CYCLES > 1 ? $clog2(WDT_CYCLES) : 1;
   localparam logic [LW-1:0] LOCK_TERM  = LW'(LOCK_CYCLES - 1);
   localparam logic [SW-1:0] STAGE_TERM = SW'(STAGE_CYCLES - 1);
   localparam logic [WW-1:0] WDT_TERM   = WW'(WDT_CYCLES - 1);
   localparam logic [CAUSE_W-1:0] CAUSE_RST = CAUSE_W'(1) << CAUSE_POR;
   state_t             state_q, state_d;
   logic [LW-1:0]      lock_q, lock_d;
   logic [SW-1:0]      stage_q, stage_d;
   logic [WW-1:0]      wdt_q, wdt_d;
   logic [CAUSE_W-1:0] cause_q, cause_d, fault;
   logic               periph_reset_q, periph_reset_d;
   logic               cpu_reset_q, cpu_reset_d;
   logic               press, locked_ok;
   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_reset),
      .press (press)
   );
   always_comb begin
      state_d   = state_q;
      lock_d    = '0;
      stage_d   = '0;
      wdt_d     = '0;
      fault     = '0;
      locked_ok = pll_locked && !btn_reset;
      unique case (state_q)
         HOLD: begin
            lock_d  = locked_ok && lock_q != LOCK_TERM ? lock_q + 1'b1 : '0;
            state_d = locked_ok && lock_q == LOCK_TERM ? PERIPH : HOLD;
         end
         PERIPH: begin
            stage_d = stage_q == STAGE_TERM ? '0 : stage_q + 1'b1;
            state_d = stage_q == STAGE_TERM ? RUN : PERIPH;
         end
         RUN: begin
            wdt_d = !wdt_en || wdt_kick ? '0 : (wdt_q == WDT_TERM ? wdt_q : wdt_q + 1'b1);
            fault[CAUSE_WDT] = wdt_en && !wdt_kick && wdt_q == WDT_TERM;
         end
         default: state_d = HOLD;
      endcase
      if (state_q != HOLD) begin
         fault[CAUSE_LOCK] = !pll_locked;
         fault[CAUSE_BTN]  = press;
      end
      if (|fault) begin
         state_d = HOLD;
         lock_d  = '0;
         stage_d = '0;
         wdt_d   = '0;
      end
      // a clear coinciding with a fault keeps only the new fault bits
      cause_d        = (cause_clr ? '0 : cause_q) | fault;
      periph_reset_d = state_d == HOLD;
      cpu_reset_d    = state_d != RUN;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= HOLD;
         lock_q         <= '0;
         stage_q        <= '0;
         wdt_q          <= '0;
         cause_q        <= CAUSE_RST;
         periph_reset_q <= 1'b1;
         cpu_reset_q    <= 1'b1;
      end else begin
         state_q        <= state_d;
         lock_q         <= lock_d;
         stage_q        <= stage_d;
         wdt_q          <= wdt_d;
         cause_q        <= cause_d;
         periph_reset_q <= periph_reset_d;
         cpu_reset_q    <= cpu_reset_d;
      end
   end
   assign periph_reset = periph_reset_q;
   assign cpu_reset    = cpu_reset_q;
   assign cause        = cause_q;
endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: directed scenarios for reset_seq with small counter limits.
module tb_reset_seq;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       pll_locked = 1'b0;
   logic       btn_reset = 1'b0;
   logic       wdt_en = 1'b0;
   logic       wdt_kick = 1'b0;
   logic       cause_clr = 1'b0;
   logic       periph_reset, cpu_reset;
   logic [3:0] cause;
   int         n_assert = 0;
   int         n_fail = 0;

   reset_seq #(
      .LOCK_CYCLES(16), .STAGE_CYCLES(8), .DEBOUNCE_CYCLES(4), .WDT_CYCLES(32)
   ) dut (
      .clk(clk), .reset(reset), .pll_locked(pll_locked), .btn_reset(btn_reset),
      .wdt_en(wdt_en), .wdt_kick(wdt_kick), .cause_clr(cause_clr),
      .periph_reset(periph_reset), .cpu_reset(cpu_reset), .cause(cause)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic p, input logic c, input logic [3:0] ca);
      n_assert++;
      assert (periph_reset === p)
      else begin
         n_fail++;
         $error("FAIL %s periph_reset: observed %b expected %b", tag, periph_reset, p);
      end
      n_assert++;
      assert (cpu_reset === c)
      else begin
         n_fail++;
         $error("FAIL %s cpu_reset: observed %b expected %b", tag, cpu_reset, c);
      end
      n_assert++;
      assert (cause === ca)
      else begin
         n_fail++;
         $error("FAIL %s cause: observed %b expected %b", tag, cause, ca);
      end
   endtask

   initial begin
      // power-up
      tick(3);
      chk("reset_held", 1, 1, 4'b0001);
      reset = 1'b0;
      pll_locked = 1'b1;
      tick(15);
      chk("pwr_edge15", 1, 1, 4'b0001);
      tick(1);
      chk("pwr_edge16", 0, 1, 4'b0001);
      tick(7);
      chk("pwr_edge23", 0, 1, 4'b0001);
      tick(1);
      chk("pwr_edge24", 0, 0, 4'b0001);
      // lock loss in RUN and re-sequence
      pll_locked = 1'b0;
      tick(1);
      chk("lockloss_run", 1, 1, 4'b0011);
      pll_locked = 1'b1;
      tick(15);
      chk("relock_15", 1, 1, 4'b0011);
      tick(1);
      chk("relock_16", 0, 1, 4'b0011);
      tick(8);
      chk("relock_run", 0, 0, 4'b0011);
      // lock glitch in HOLD at count 10
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(10);
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(15);
      chk("glitch_15", 1, 1, 4'b0011);
      tick(1);
      chk("glitch_16", 0, 1, 4'b0011);
      tick(8);
      chk("glitch_run", 0, 0, 4'b0011);
      // clear cause
      cause_clr = 1'b1;
      tick(1);
      cause_clr = 1'b0;
      chk("cause_clr", 0, 0, 4'b0000);
      // short button press ignored
      btn_reset = 1'b1;
      tick(3);
      btn_reset = 1'b0;
      tick(1);
      chk("btn_short", 0, 0, 4'b0000);
      // debounced press, then held in HOLD
      btn_reset = 1'b1;
      tick(3);
      chk("btn_3", 0, 0, 4'b0000);
      tick(1);
      chk("btn_4", 1, 1, 4'b0100);
      tick(96);
      chk("btn_held", 1, 1, 4'b0100);
      btn_reset = 1'b0;
      tick(15);
      chk("btn_rel_15", 1, 1, 4'b0100);
      tick(1);
      chk("btn_rel_16", 0, 1, 4'b0100);
      tick(8);
      chk("btn_run", 0, 0, 4'b0100);
      // watchdog kicked every 20 cycles
      wdt_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(19);
         wdt_kick = 1'b1;
         tick(1);
         wdt_kick = 1'b0;
      end
      chk("wdt_kicked", 0, 0, 4'b0100);
      // kick on the terminal cycle wins
      tick(31);
      wdt_kick = 1'b1;
      tick(1);
      wdt_kick = 1'b0;
      chk("wdt_tie", 0, 0, 4'b0100);
      // expiry
      tick(31);
      chk("wdt_31", 0, 0, 4'b0100);
      tick(1);
      chk("wdt_expire", 1, 1, 4'b1100);
      wdt_en = 1'b0;
      tick(24);
      chk("wdt_reseq", 0, 0, 4'b1100);
      // clear and lock loss in the same cycle
      cause_clr = 1'b1;
      pll_locked = 1'b0;
      tick(1);
      cause_clr = 1'b0;
      pll_locked = 1'b1;
      chk("clr_collide", 1, 1, 4'b0010);
      // reset mid-sequence
      tick(19);
      chk("mid_periph", 0, 1, 4'b0010);
      reset = 1'b1;
      tick(1);
      chk("mid_reset", 1, 1, 4'b0001);
      reset = 1'b0;
      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
